sync_fifo_core: RTL and testbench

//  Synchronous single-clock FIFO: the DUT behind fifo_if that the monitor samples each negedge.

---
 rtl/sync_fifo_core.sv | 114 +++++++++++
 tb/tb_sync_fifo_core.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock FIFO, registered handshakes, decoded level flags.
// Define SYNC_FIFO_COUNT_EN to expose the occupancy counter on fifo_count.
module sync_fifo_core #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
`ifdef SYNC_FIFO_COUNT_EN
  output logic                  almostempty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`else
  output logic                  almostempty
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [FIFO_WIDTH-1:0] r_data_out;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_afull;
  logic w_empty;
  logic w_aempty;
  logic w_wr_ok;
  logic w_rd_ok;

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_afull  = (r_count == CW'(FIFO_DEPTH - 1));
  assign w_empty  = (r_count == '0);
  assign w_aempty = (r_count == CW'(1));

  // Acceptance uses only the pre-edge flags, so full+both reads and
  // empty+both writes without any same-cycle bypass.
  assign w_wr_ok = wr_en & ~w_full;
  assign w_rd_ok = rd_en & ~w_empty;

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= data_in;
  end

  // Write pointer and write-side handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_wr_ack   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ack   <= w_wr_ok;
      r_overflow <= wr_en & w_full;
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
    end
  end

  // Read pointer, registered read data and underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_data_out  <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= rd_en & w_empty;
      if (w_rd_ok) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy moves only when exactly one side is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign wr_ack      = r_wr_ack;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign full        = w_full;
  assign almostfull  = w_afull;
  assign empty       = w_empty;
  assign almostempty = w_aempty;
`ifdef SYNC_FIFO_COUNT_EN
  assign fifo_count  = r_count;
`endif

endmodule

// File: tb/tb_sync_fifo_core.sv
// tb_sync_fifo_core: scoreboard bench for sync_fifo_core.
// Queue-based reference model; monitor compares on every negedge.
module tb_sync_fifo_core;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk;
  logic         rst_n;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         wr_ack;
  logic         overflow;
  logic         underflow;
  logic         full;
  logic         almostfull;
  logic         empty;
  logic         almostempty;
`ifdef SYNC_FIFO_COUNT_EN
  logic [$clog2(D):0] fifo_count;
`endif

  sync_fifo_core #(
    .FIFO_WIDTH(W),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .data_in(data_in),
    .data_out(data_out),
    .wr_ack(wr_ack),
    .overflow(overflow),
    .underflow(underflow),
    .full(full),
    .almostfull(almostfull),
    .empty(empty),
`ifdef SYNC_FIFO_COUNT_EN
    .almostempty(almostempty),
    .fifo_count(fifo_count)
`else
    .almostempty(almostempty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit      ack;
    bit      ovf;
    bit      unf;
    int      dout;
    int      cnt;
  } exp_t;

  exp_t exq[$];
  int   mq[$];
  int   m_dout;
  int   errors;
  int   checks;

  task automatic check(input string n, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, expv, $time);
    end
  endtask

  task automatic check_flags(input int cnt);
    check("empty", int'(empty), int'(cnt == 0));
    check("almostempty", int'(almostempty), int'(cnt == 1));
    check("almostfull", int'(almostfull), int'(cnt == D - 1));
    check("full", int'(full), int'(cnt == D));
`ifdef SYNC_FIFO_COUNT_EN
    check("fifo_count", int'(fifo_count), cnt);
`endif
  endtask

  // One clock of stimulus; expectation is queued once the edge has happened.
  task automatic cycle(input bit w, input bit r, input int d);
    exp_t e;
    bit wok;
    bit rok;
    wr_en   = w;
    rd_en   = r;
    data_in = W'(d);
    wok = w && (mq.size() < D);
    rok = r && (mq.size() > 0);
    if (rok) m_dout = mq.pop_front();
    if (wok) mq.push_back(d & 16'hFFFF);
    e.ack  = wok;
    e.ovf  = w && !wok;
    e.unf  = r && !rok;
    e.dout = m_dout;
    e.cnt  = mq.size();
    @(posedge clk);
    exq.push_back(e);
    #1;
  endtask

  // Monitor: pop one expectation per clock the DUT has produced.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && exq.size() > 0) begin
        e = exq.pop_front();
        check("wr_ack", int'(wr_ack), int'(e.ack));
        check("overflow", int'(overflow), int'(e.ovf));
        check("underflow", int'(underflow), int'(e.unf));
        check("data_out", int'(data_out), e.dout);
        check_flags(e.cnt);
      end
    end
  end

  // Async reset asserted mid-cycle, checked before any clock edge.
  task automatic mid_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    mq.delete();
    m_dout = 0;
    check("rst data_out", int'(data_out), 0);
    check("rst wr_ack", int'(wr_ack), 0);
    check("rst overflow", int'(overflow), 0);
    check("rst underflow", int'(underflow), 0);
    check_flags(0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    errors  = 0;
    checks  = 0;
    m_dout  = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("init data_out", int'(data_out), 0);
    check("init underflow", int'(underflow), 0);
    check_flags(0);
    rst_n = 1'b1;

    // Read of empty FIFO after reset.
    cycle(1'b0, 1'b1, 0);
    cycle(1'b0, 1'b0, 0);

    // Fill to full, then one rejected write.
    for (int i = 1; i <= D; i++) cycle(1'b1, 1'b0, i);
    cycle(1'b1, 1'b0, 16'hFFFF);

    // Full with both requests: read wins, write overflows.
    cycle(1'b1, 1'b1, 16'hBEEF);

    // Drain completely.
    for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, 0);
    cycle(1'b0, 1'b1, 0);

    // Empty with both requests: write wins, read underflows.
    cycle(1'b1, 1'b1, 16'h1234);
    cycle(1'b0, 1'b1, 0);

    // Occupancy 4 with streaming traffic, pointers wrap.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'h0A00 + i);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, int'($urandom_range(0, 16'hFFFF)));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 0);

    // Reset in the middle of a burst at occupancy 5.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'h5500 + i);
    mid_reset();
    cycle(1'b0, 1'b1, 0);
    cycle(1'b1, 1'b0, 16'h7777);
    cycle(1'b0, 1'b1, 0);
    cycle(1'b0, 1'b0, 0);

    // Random traffic, biased to visit both extremes.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 50; i++) begin
        bit w;
        bit r;
        w = ($urandom_range(0, 9) < ((k % 2) ? 3 : 7));
        r = ($urandom_range(0, 9) < ((k % 2) ? 7 : 3));
        cycle(w, r, int'($urandom_range(0, 16'hFFFF)));
      end
    end
    cycle(1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard drained", exq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
